// File: rtl/cjb_call_ret_ctrl_v.sv
// cjbRISC subroutine call/return sequencer.
// Turns single-cycle CALL/RET requests into timed pushes/pops on the
// hardware return-address stack, and into PC-load pulses.
// Also tracks stack occupancy with sticky overflow/underflow flags.
module cjb_call_ret_ctrl_v #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             call,
  input  logic             ret,
  input  logic [WIDTH-1:0] ret_addr,
  input  logic [WIDTH-1:0] target,
  input  logic [WIDTH-1:0] stk_dout,
  output logic             stk_push,
  output logic             stk_pop,
  output logic [WIDTH-1:0] stk_din,
  output logic             pc_load,
  output logic [WIDTH-1:0] pc_out,
  output logic             busy,
  output logic [2:0]       depth,
  output logic             ovf,
  output logic             unf
);

  localparam int unsigned DEPTH_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CPUSH = 2'd1,
    RPOP  = 2'd2,
    RCAP  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   addr_q, addr_d;
  logic [WIDTH-1:0]   tgt_q, tgt_d;
  logic [WIDTH-1:0]   pc_out_q, pc_out_d;
  logic               pc_load_q, pc_load_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;

  // State and datapath registers; Reset is synchronous and dominant.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      tgt_q     <= '0;
      pc_out_q  <= '0;
      pc_load_q <= 1'b0;
      depth_q   <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      tgt_q     <= tgt_d;
      pc_out_q  <= pc_out_d;
      pc_load_q <= pc_load_d;
      depth_q   <= depth_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

  // Next-state, occupancy tracking and PC-load sequencing.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    tgt_d     = tgt_q;
    pc_out_d  = pc_out_q;
    pc_load_d = 1'b0;
    depth_d   = depth_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    unique case (state_q)
      IDLE: begin
        // CALL wins over a simultaneous RET; the RET is dropped.
        if (call) begin
          addr_d  = ret_addr;
          tgt_d   = target;
          state_d = CPUSH;
        end else if (ret) begin
          state_d = RPOP;
        end
      end
      CPUSH: begin
        pc_out_d  = tgt_q;
        pc_load_d = 1'b1;
        state_d   = IDLE;
        // A full stack drops its oldest entry, so occupancy saturates.
        if (depth_q == DEPTH_W'(DEPTH)) begin
          ovf_d = 1'b1;
        end else begin
          depth_d = depth_q + DEPTH_W'(1);
        end
      end
      RPOP: begin
        state_d = RCAP;
        // An empty stack returns zero; occupancy stays at zero.
        if (depth_q == '0) begin
          unf_d = 1'b1;
        end else begin
          depth_d = depth_q - DEPTH_W'(1);
        end
      end
      RCAP: begin
        pc_out_d  = stk_dout;
        pc_load_d = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Stack strobes decode straight from state; they are mutually exclusive.
  assign stk_push = (state_q == CPUSH);
  assign stk_pop  = (state_q == RPOP);
  assign busy     = (state_q != IDLE);
  assign stk_din  = addr_q;
  assign pc_out   = pc_out_q;
  assign pc_load  = pc_load_q;
  assign depth    = depth_q;
  assign ovf      = ovf_q;
  assign unf      = unf_q;

endmodule

// File: tb/tb_cjb_call_ret_ctrl_v.sv
// Bench for cjb_call_ret_ctrl_v.
// Pairs the controller with a behavioural 8x4 LIFO and checks it against
// hand-computed vectors and sequences.
module tb_cjb_call_ret_ctrl_v;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       call, ret;
  logic [7:0] ret_addr, target, stk_dout;
  logic       stk_push, stk_pop, pc_load, busy, ovf, unf;
  logic [7:0] stk_din, pc_out;
  logic [2:0] depth;

  int checks = 0;
  int errors = 0;

  cjb_call_ret_ctrl_v #(.WIDTH(8), .DEPTH(4)) dut (
    .Clock(Clock), .Reset(Reset), .call(call), .ret(ret),
    .ret_addr(ret_addr), .target(target), .stk_dout(stk_dout),
    .stk_push(stk_push), .stk_pop(stk_pop), .stk_din(stk_din),
    .pc_load(pc_load), .pc_out(pc_out), .busy(busy), .depth(depth),
    .ovf(ovf), .unf(unf)
  );

  always #5 Clock = ~Clock;

  // Behavioural stack: overflow discards oldest, underflow returns 0x00.
  logic [7:0] stk [4];
  logic [2:0] scnt;
  logic [2:0] scnt_m1;
  assign scnt_m1 = scnt - 3'd1;
  always_ff @(posedge Clock) begin
    if (Reset) begin
      scnt     <= 3'd0;
      stk_dout <= 8'h00;
    end else if (stk_push) begin
      if (scnt == 3'd4) begin
        stk[0] <= stk[1];
        stk[1] <= stk[2];
        stk[2] <= stk[3];
        stk[3] <= stk_din;
      end else begin
        stk[scnt[1:0]] <= stk_din;
        scnt <= scnt + 3'd1;
      end
    end else if (stk_pop) begin
      if (scnt != 3'd0) begin
        stk_dout <= stk[scnt_m1[1:0]];
        scnt     <= scnt_m1;
      end else begin
        stk_dout <= 8'h00;
      end
    end
  end

  typedef struct {
    logic       rst, c, r;
    logic [7:0] ra, tg;
    logic       push, pop;
    logic [7:0] din;
    logic       pl;
    logic [7:0] pc;
    logic       bsy;
    logic [2:0] dep;
    logic       ov, un;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input vec_t v);
    chk({tag, " push"},  {7'd0, stk_push}, {7'd0, v.push});
    chk({tag, " pop"},   {7'd0, stk_pop},  {7'd0, v.pop});
    chk({tag, " din"},   stk_din,          v.din);
    chk({tag, " pl"},    {7'd0, pc_load},  {7'd0, v.pl});
    chk({tag, " pc"},    pc_out,           v.pc);
    chk({tag, " busy"},  {7'd0, busy},     {7'd0, v.bsy});
    chk({tag, " depth"}, {5'd0, depth},    {5'd0, v.dep});
    chk({tag, " ovf"},   {7'd0, ovf},      {7'd0, v.ov});
    chk({tag, " unf"},   {7'd0, unf},      {7'd0, v.un});
  endtask

  task automatic step();
    @(posedge Clock);
    @(negedge Clock);
  endtask

  task automatic do_reset();
    Reset = 1'b1; call = 1'b0; ret = 1'b0;
    step();
    Reset = 1'b0;
  endtask

  // CALL from IDLE: checks push cycle and the PC-load cycle.
  task automatic do_call(input logic [7:0] ra, input logic [7:0] tg, input string tag);
    call = 1'b1; ret_addr = ra; target = tg;
    step();
    call = 1'b0;
    chk({tag, " push"}, {7'd0, stk_push}, 8'd1);
    chk({tag, " din"},  stk_din, ra);
    step();
    chk({tag, " pl"}, {7'd0, pc_load}, 8'd1);
    chk({tag, " pc"}, pc_out, tg);
  endtask

  // RET from IDLE: pop cycle, capture cycle, then PC-load cycle.
  task automatic do_ret(input logic [7:0] exp_pc, input string tag);
    ret = 1'b1;
    step();
    ret = 1'b0;
    chk({tag, " pop"}, {7'd0, stk_pop}, 8'd1);
    step();
    chk({tag, " rcap busy"}, {7'd0, busy}, 8'd1);
    chk({tag, " rcap pl"}, {7'd0, pc_load}, 8'd0);
    step();
    chk({tag, " pl"}, {7'd0, pc_load}, 8'd1);
    chk({tag, " pc"}, pc_out, exp_pc);
  endtask

  initial begin
    // rst c r ra tg | push pop din pl pc busy dep ovf unf
    vecs[0]  = '{0,1,0,8'h11,8'h40, 0,0,8'h00,0,8'h00,0,3'd0,0,0};
    vecs[1]  = '{0,0,0,8'h00,8'h00, 1,0,8'h11,0,8'h00,1,3'd0,0,0};
    vecs[2]  = '{0,0,0,8'h00,8'h00, 0,0,8'h11,1,8'h40,0,3'd1,0,0};
    vecs[3]  = '{1,0,0,8'h00,8'h00, 0,0,8'h11,0,8'h40,0,3'd1,0,0};
    vecs[4]  = '{0,1,0,8'h11,8'h41, 0,0,8'h00,0,8'h00,0,3'd0,0,0};
    vecs[5]  = '{0,0,0,8'h00,8'h00, 1,0,8'h11,0,8'h00,1,3'd0,0,0};
    vecs[6]  = '{0,1,0,8'h22,8'h42, 0,0,8'h11,1,8'h41,0,3'd1,0,0};
    vecs[7]  = '{0,0,0,8'h00,8'h00, 1,0,8'h22,0,8'h41,1,3'd1,0,0};
    vecs[8]  = '{0,1,0,8'h33,8'h43, 0,0,8'h22,1,8'h42,0,3'd2,0,0};
    vecs[9]  = '{0,0,0,8'h00,8'h00, 1,0,8'h33,0,8'h42,1,3'd2,0,0};
    vecs[10] = '{0,0,1,8'h00,8'h00, 0,0,8'h33,1,8'h43,0,3'd3,0,0};
    vecs[11] = '{0,0,0,8'h00,8'h00, 0,1,8'h33,0,8'h43,1,3'd3,0,0};
    vecs[12] = '{0,0,0,8'h00,8'h00, 0,0,8'h33,0,8'h43,1,3'd2,0,0};
    vecs[13] = '{0,0,1,8'h00,8'h00, 0,0,8'h33,1,8'h33,0,3'd2,0,0};
    vecs[14] = '{0,0,0,8'h00,8'h00, 0,1,8'h33,0,8'h33,1,3'd2,0,0};
    vecs[15] = '{0,0,0,8'h00,8'h00, 0,0,8'h33,0,8'h33,1,3'd1,0,0};
    vecs[16] = '{0,0,1,8'h00,8'h00, 0,0,8'h33,1,8'h22,0,3'd1,0,0};
    vecs[17] = '{0,0,0,8'h00,8'h00, 0,1,8'h33,0,8'h22,1,3'd1,0,0};
    vecs[18] = '{0,0,0,8'h00,8'h00, 0,0,8'h33,0,8'h22,1,3'd0,0,0};
    vecs[19] = '{0,0,0,8'h00,8'h00, 0,0,8'h33,1,8'h11,0,3'd0,0,0};
    // call+ret together, then ret while busy: both RETs must vanish
    vecs[20] = '{0,1,1,8'h77,8'h78, 0,0,8'h33,0,8'h11,0,3'd0,0,0};
    vecs[21] = '{0,0,1,8'h00,8'h00, 1,0,8'h77,0,8'h11,1,3'd0,0,0};
    vecs[22] = '{0,0,0,8'h00,8'h00, 0,0,8'h77,1,8'h78,0,3'd1,0,0};
    vecs[23] = '{0,0,0,8'h00,8'h00, 0,0,8'h77,0,8'h78,0,3'd1,0,0};

    Reset = 1'b1; call = 1'b0; ret = 1'b0; ret_addr = 8'h00; target = 8'h00;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b0;

    // Table: outputs checked for the current cycle, then row inputs driven.
    for (int i = 0; i < NV; i++) begin
      chk_all($sformatf("v%0d", i), vecs[i]);
      Reset = vecs[i].rst; call = vecs[i].c; ret = vecs[i].r;
      ret_addr = vecs[i].ra; target = vecs[i].tg;
      step();
    end
    Reset = 1'b0; call = 1'b0; ret = 1'b0;

    // Five CALLs overflow a 4-deep stack; five RETs underflow it.
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      do_call(8'(i), 8'(8'h80 + i), $sformatf("ovf call%0d", i));
    end
    chk("ovf depth", {5'd0, depth}, 8'd4);
    chk("ovf flag", {7'd0, ovf}, 8'd1);
    chk("ovf unf clear", {7'd0, unf}, 8'd0);
    for (int i = 0; i < 5; i++) begin
      logic [7:0] e;
      e = (i < 4) ? 8'(5 - i) : 8'h00;
      do_ret(e, $sformatf("unf ret%0d", i));
      if (i == 3) chk("unf before last", {7'd0, unf}, 8'd0);
    end
    chk("unf flag", {7'd0, unf}, 8'd1);
    chk("unf depth", {5'd0, depth}, 8'd0);
    chk("ovf sticky", {7'd0, ovf}, 8'd1);

    // Reset in RPOP aborts the return with no PC load.
    do_reset();
    do_call(8'h44, 8'h50, "abort call");
    ret = 1'b1;
    step();
    ret = 1'b0;
    chk("abort in rpop", {7'd0, stk_pop}, 8'd1);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    chk("abort busy", {7'd0, busy}, 8'd0);
    chk("abort pop", {7'd0, stk_pop}, 8'd0);
    chk("abort push", {7'd0, stk_push}, 8'd0);
    chk("abort din", stk_din, 8'h00);
    chk("abort pc", pc_out, 8'h00);
    chk("abort depth", {5'd0, depth}, 8'd0);
    chk("abort ovf", {7'd0, ovf}, 8'd0);
    chk("abort unf", {7'd0, unf}, 8'd0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("abort no pl%0d", i), {7'd0, pc_load}, 8'd0);
      step();
    end
    do_call(8'h55, 8'h60, "post call");
    do_ret(8'h55, "post ret");
    chk("post depth", {5'd0, depth}, 8'd0);
    chk("post unf", {7'd0, unf}, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
